// File: rtl/fp_sub.sv
// -----------------------------------------------------------------------------
// fp_sub : multi-cycle IEEE-754 single-precision subtractor, diff = a - b.
//
// The subtrahend's sign is inverted and the operation is carried out as a
// signed-magnitude add. Alignment and normalisation shift one bit per cycle.
// Denormal inputs flush to zero, results truncate toward zero.
//
// Ports
//   clk    in   1   rising-edge clock
//   reset  in   1   synchronous active-high reset
//   start  in   1   request, sampled only while idle
//   a      in  32   minuend
//   b      in  32   subtrahend
//   diff   out 32   result, held until the next completion or reset
//   done   out  1   one-cycle pulse, diff valid
//   busy   out  1   high from start accept until the done edge
// -----------------------------------------------------------------------------
module fp_sub #(
  parameter int unsigned ALIGN_MAX = 25,
  parameter logic [31:0] QNAN      = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_ALIGN = 3'd2,
    S_EXEC  = 3'd3,
    S_NORM  = 3'd4,
    S_PACK  = 3'd5
  } state_t;

  localparam logic [4:0] ALIGN_CAP = ALIGN_MAX[4:0];
  localparam logic [7:0] ALIGN_LIM = ALIGN_MAX[7:0];

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] diff_q, diff_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        spec_q, spec_d;
  logic [31:0] spec_val_q, spec_val_d;
  logic [7:0]  exp_q, exp_d;
  logic [23:0] mant_l_q, mant_l_d;   // operand with the larger exponent
  logic [23:0] mant_s_q, mant_s_d;   // operand being aligned
  logic        sign_l_q, sign_l_d;
  logic        sign_s_q, sign_s_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [24:0] res_mant_q, res_mant_d;
  logic        res_sign_q, res_sign_d;
  logic        zero_q, zero_d;

  // Operand decode of the captured inputs (b carries the inverted sign).
  logic [7:0]  exp_a_s, exp_b_s, exp_diff_s;
  logic        sign_a_s, sign_b_s;
  logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic        a_big_s;
  logic [4:0]  align_cnt_s;
  logic        special_s;
  logic [31:0] special_val_s;
  logic [24:0] sum_s;
  logic        exec_sign_s, exec_zero_s;

  assign exp_a_s  = a_q[30:23];
  assign exp_b_s  = b_q[30:23];
  assign sign_a_s = a_q[31];
  assign sign_b_s = ~b_q[31];
  assign a_nan_s  = (exp_a_s == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan_s  = (exp_b_s == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf_s  = (exp_a_s == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf_s  = (exp_b_s == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_zero_s = (exp_a_s == 8'd0);
  assign b_zero_s = (exp_b_s == 8'd0);
  assign a_big_s  = (exp_a_s >= exp_b_s);
  assign exp_diff_s  = a_big_s ? (exp_a_s - exp_b_s) : (exp_b_s - exp_a_s);
  assign align_cnt_s = (exp_diff_s >= ALIGN_LIM) ? ALIGN_CAP : exp_diff_s[4:0];

  // Special-case resolution in priority order; a raw inf-inf with equal
  // stored signs is the invalid case (the subtract turns it into inf + -inf).
  always_comb begin
    special_s     = 1'b1;
    special_val_s = QNAN;
    if (a_nan_s || b_nan_s) begin
      special_val_s = QNAN;
    end else if (a_inf_s && b_inf_s && (a_q[31] == b_q[31])) begin
      special_val_s = QNAN;
    end else if (a_inf_s) begin
      special_val_s = a_q;
    end else if (b_inf_s) begin
      special_val_s = {~b_q[31], b_q[30:0]};
    end else if (a_zero_s) begin
      special_val_s = {~b_q[31], b_q[30:0]};
    end else if (b_zero_s) begin
      special_val_s = a_q;
    end else begin
      special_s     = 1'b0;
      special_val_s = QNAN;
    end
  end

  // Signed-magnitude add of the aligned mantissas.
  always_comb begin
    sum_s       = 25'd0;
    exec_sign_s = sign_l_q;
    exec_zero_s = 1'b0;
    if (sign_l_q == sign_s_q) begin
      sum_s       = {1'b0, mant_l_q} + {1'b0, mant_s_q};
      exec_sign_s = sign_l_q;
    end else if (mant_l_q > mant_s_q) begin
      sum_s       = {1'b0, mant_l_q} - {1'b0, mant_s_q};
      exec_sign_s = sign_l_q;
    end else if (mant_s_q > mant_l_q) begin
      sum_s       = {1'b0, mant_s_q} - {1'b0, mant_l_q};
      exec_sign_s = sign_s_q;
    end else begin
      sum_s       = 25'd0;
      exec_sign_s = 1'b0;
      exec_zero_s = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CHECK;
        else       state_d = S_IDLE;
      end
      S_CHECK: begin
        if (special_s)                 state_d = S_PACK;
        else if (exp_diff_s == 8'd0)   state_d = S_EXEC;
        else                           state_d = S_ALIGN;
      end
      S_ALIGN: begin
        if (cnt_q == 5'd1) state_d = S_EXEC;
        else               state_d = S_ALIGN;
      end
      S_EXEC: begin
        if (exec_zero_s)                    state_d = S_PACK;
        else if (sum_s[24] || !sum_s[23])   state_d = S_NORM;
        else                                state_d = S_PACK;
      end
      S_NORM: begin
        // After a carry shift or an underflow the result is final; otherwise
        // stop once the bit about to land in position 23 is a one.
        if (res_mant_q[24])           state_d = S_PACK;
        else if (exp_q == 8'd1)       state_d = S_PACK;
        else if (res_mant_q[22])      state_d = S_PACK;
        else                          state_d = S_NORM;
      end
      S_PACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values per state.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    diff_d     = diff_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    exp_d      = exp_q;
    mant_l_d   = mant_l_q;
    mant_s_d   = mant_s_q;
    sign_l_d   = sign_l_q;
    sign_s_d   = sign_s_q;
    cnt_d      = cnt_q;
    res_mant_d = res_mant_q;
    res_sign_d = res_sign_q;
    zero_d     = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          busy_d = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_CHECK: begin
        spec_d     = special_s;
        spec_val_d = special_val_s;
        zero_d     = 1'b0;
        cnt_d      = align_cnt_s;
        if (a_big_s) begin
          exp_d    = exp_a_s;
          mant_l_d = {1'b1, a_q[22:0]};
          sign_l_d = sign_a_s;
          mant_s_d = {1'b1, b_q[22:0]};
          sign_s_d = sign_b_s;
        end else begin
          exp_d    = exp_b_s;
          mant_l_d = {1'b1, b_q[22:0]};
          sign_l_d = sign_b_s;
          mant_s_d = {1'b1, a_q[22:0]};
          sign_s_d = sign_a_s;
        end
      end
      S_ALIGN: begin
        mant_s_d = mant_s_q >> 1;
        cnt_d    = cnt_q - 5'd1;
      end
      S_EXEC: begin
        res_mant_d = sum_s;
        res_sign_d = exec_sign_s;
        zero_d     = exec_zero_s;
      end
      S_NORM: begin
        if (res_mant_q[24]) begin
          res_mant_d = res_mant_q >> 1;
          exp_d      = exp_q + 8'd1;
        end else if (exp_q == 8'd1) begin
          zero_d = 1'b1;
          exp_d  = 8'd0;
        end else begin
          res_mant_d = res_mant_q << 1;
          exp_d      = exp_q - 8'd1;
        end
      end
      S_PACK: begin
        done_d = 1'b1;
        busy_d = 1'b0;
        if (spec_q) begin
          diff_d = spec_val_q;
        end else if (zero_q || !res_mant_q[23]) begin
          diff_d = 32'h00000000;
        end else if (exp_q == 8'hFF) begin
          diff_d = {res_sign_q, 8'hFF, 23'd0};
        end else begin
          diff_d = {res_sign_q, exp_q, res_mant_q[22:0]};
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      diff_q     <= 32'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
      exp_q      <= 8'd0;
      mant_l_q   <= 24'd0;
      mant_s_q   <= 24'd0;
      sign_l_q   <= 1'b0;
      sign_s_q   <= 1'b0;
      cnt_q      <= 5'd0;
      res_mant_q <= 25'd0;
      res_sign_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      diff_q     <= diff_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      exp_q      <= exp_d;
      mant_l_q   <= mant_l_d;
      mant_s_q   <= mant_s_d;
      sign_l_q   <= sign_l_d;
      sign_s_q   <= sign_s_d;
      cnt_q      <= cnt_d;
      res_mant_q <= res_mant_d;
      res_sign_q <= res_sign_d;
      zero_q     <= zero_d;
    end
  end

  assign diff = diff_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_fp_sub.sv
// -----------------------------------------------------------------------------
// tb_fp_sub : directed scoreboard bench for fp_sub. The driver pushes the
// hand-computed result and latency for each request; a monitor on the falling
// edge pops and compares whenever done is seen.
// -----------------------------------------------------------------------------
module tb_fp_sub;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] diff;
  logic        done, busy;

  typedef struct {
    logic [31:0] d;
    int          lat;
    string       nm;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   accept_cyc  = 0;
  logic busy_prev   = 1'b0;

  fp_sub dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .diff  (diff),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h expected=%h", nm, act, req);
    end
  endtask

  // Monitor: remember the accept cycle, check each completion against the queue.
  always @(negedge clk) begin
    if (busy === 1'b1 && busy_prev !== 1'b1) accept_cyc = cyc;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done actual=%h expected=no_done", diff);
      end else begin
        mon_e = sb_q.pop_front();
        chk({mon_e.nm, "_diff"}, diff, mon_e.d);
        chk({mon_e.nm, "_latency"}, 32'(cyc - accept_cyc), 32'(mon_e.lat));
        chk({mon_e.nm, "_busy_low"}, {31'd0, busy}, 32'd0);
      end
    end
    busy_prev = busy;
  end

  task automatic wait_sb(input int target, input string nm);
    int waited = 0;
    while (sb_q.size() > target && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (sb_q.size() > target) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout actual=pending expected=done", nm);
      sb_q.delete();
    end
  endtask

  task automatic run_vec(input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] ed, input int lat, input string nm);
    exp_t e;
    e.d = ed; e.lat = lat; e.nm = nm;
    @(negedge clk);
    a = va; b = vb; start = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;  // operands may change freely while busy
    b = $urandom;
    wait_sb(0, nm);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; start = 1'b0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_diff", diff, 32'h00000000);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    run_vec(32'h40400000, 32'h3F800000, 32'h40000000,  4, "three_minus_one");
    run_vec(32'h3F800000, 32'h3FC00000, 32'hBF000000,  4, "neg_half");
    run_vec(32'h3F800000, 32'h3F800000, 32'h00000000,  3, "cancel");
    run_vec(32'h3F800000, 32'hBF800000, 32'h40000000,  4, "eff_add_carry");
    run_vec(32'h7F800000, 32'h7F800000, 32'h7FC00000,  2, "inf_minus_inf");
    run_vec(32'h00000000, 32'h3F800000, 32'hBF800000,  2, "zero_minus_one");
    run_vec(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000,  4, "overflow");
    run_vec(32'h4B800000, 32'h33800000, 32'h4B800000, 28, "align_cap");
    run_vec(32'h7FC00001, 32'h3F800000, 32'h7FC00000,  2, "nan_in");
    run_vec(32'h3F800000, 32'h7F800000, 32'hFF800000,  2, "b_inf");
    run_vec(32'hFF800000, 32'h3F800000, 32'hFF800000,  2, "a_inf");
    run_vec(32'h40400000, 32'h00000000, 32'h40400000,  2, "b_zero");
    run_vec(32'h00000001, 32'h3F800000, 32'hBF800000,  2, "denorm_flush");
    run_vec(32'h3F800000, 32'h40400000, 32'hC0000000,  4, "one_minus_three");
    run_vec(32'h00C00000, 32'h00800000, 32'h00000000,  4, "underflow");
    run_vec(32'h3F800001, 32'h3F800000, 32'h34000000, 26, "long_norm");
    run_vec(32'h3F800000, 32'hB3800000, 32'h3F800000, 27, "truncate");

    // start held high: one completion, then a second accept after done.
    e.d = 32'h40000000; e.lat = 4; e.nm = "hold_start_1";
    @(negedge clk);
    a = 32'h40400000; b = 32'h3F800000; start = 1'b1;
    sb_q.push_back(e);
    e.nm = "hold_start_2";
    sb_q.push_back(e);
    wait_sb(1, "hold_start_1");
    @(negedge clk);
    chk("hold_start_reaccept_busy", {31'd0, busy}, 32'd1);
    start = 1'b0;
    a = $urandom; b = $urandom;
    wait_sb(0, "hold_start_2");

    // Reset two cycles after accept drops the computation.
    @(negedge clk);
    a = 32'h40400000; b = 32'h3F800000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midop_reset_diff", diff, 32'h00000000);
    chk("midop_reset_busy", {31'd0, busy}, 32'd0);
    chk("midop_reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    run_vec(32'h40400000, 32'h3F800000, 32'h40000000, 4, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_sub.md
Name: fp_sub

Overview:
Multi-cycle IEEE-754 single-precision subtractor that computes diff = a - b under a start/done handshake. It is the subtract-direction companion to the team's FP adder and shares that block's unpack, align, normalise and pack datapath style. It runs as a sequential FSM: alignment and normalisation each shift one bit per cycle. The block sits beside the adder in the FP unit, and the issuing controller selects the block by opcode.

Parameters:
ALIGN_MAX, 25, alignment shift cap; an operand whose exponent difference is at least this value contributes zero.
QNAN, 32'h7FC00000, canonical NaN value returned for every invalid or NaN result.

Ports:
clk  input  1  rising-edge clock; the only clock in the block.
reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
start  input  1  request; sampled only in IDLE.
a  input  32  minuend, IEEE-754 single precision.
b  input  32  subtrahend, IEEE-754 single precision.
diff  output  32  result; holds its value until the next completion or reset.
done  output  1  one-cycle pulse marking diff valid.
busy  output  1  high from the start-accept edge until the done edge.

Behaviour:
- Reset (synchronous, active-high): diff=0, done=0, busy=0, FSM=IDLE, all internal registers cleared. Reset wins over every other event, including mid-operation; a computation in flight is dropped with no done.
- Handshake: in IDLE with start=1, capture a/b on that edge (edge E0) and set busy=1. start is ignored while busy=1, and operands are not re-sampled. done=1 for exactly one cycle, on the same edge that writes diff and clears busy. A new start may be accepted in the cycle after done.
- Unpack: b's sign is inverted, and the operation becomes a signed-magnitude add of a and -b. Any exponent of 0 is treated as zero (denormals flush to zero). The hidden 1 is prepended, giving a 24-bit mantissa plus a 1-bit carry.
- FSM states and transitions:
  - IDLE -> CHECK on start.
  - CHECK (1 cycle): resolve special cases, in this priority order:
    - either operand NaN (exp=255, man!=0) -> QNAN.
    - a=inf and b=inf with the same sign -> QNAN.
    - a=inf -> a.
    - b=inf -> b with its sign flipped.
    - a=0 -> b with its sign flipped.
    - b=0 -> a.
    - A special case goes straight to PACK. Otherwise go to ALIGN if the exponent difference d>0, or to EXEC if d=0.
  - ALIGN: shift the smaller-exponent mantissa right one bit per cycle, for k=min(d,ALIGN_MAX) cycles. Shifted-out bits are discarded. Result exponent = larger exponent.
  - EXEC (1 cycle):
    - Same effective signs: add mantissas; sign = common sign.
    - Otherwise: subtract the smaller magnitude from the larger; sign = sign of the larger magnitude.
    - Equal magnitudes: result +0, go to PACK.
  - NORM: m cycles.
    - Carry set: one right shift and exponent+1 (m=1).
    - Otherwise: left shift with exponent-1 per cycle until bit 23 is 1 (m=0..23).
  - PACK (1 cycle): write diff and pulse done, then return to IDLE.
- Latency: special case = 2 edges after E0. Normal case = 3+k+m edges after E0. Worst case = 3+25+23 = 51.
- Rounding: truncation toward zero, with no guard or sticky bits.
- Overflow: exponent reaching 255 after NORM -> sign, 8'hFF, 23'b0 (±inf).
- Underflow: exponent reaching 0 during NORM -> +0 (32'h00000000); NORM stops immediately.
- a and b may change freely while busy without affecting the result.

Test Plan:
- Normal subtract: reset, then a=0x40400000 (3.0), b=0x3F800000 (1.0), start for 1 cycle -> diff=0x40000000, done high exactly 4 edges after accept, busy low afterwards.
- Negative result and cancellation:
  - a=0x3F800000, b=0x3FC00000 -> diff=0xBF000000 (-0.5).
  - a=b=0x3F800000 -> diff=0x00000000, done at 3 edges.
- Effective add with carry: a=0x3F800000, b=0xBF800000 -> diff=0x40000000 (2.0).
- Specials and overflow:
  - a=b=0x7F800000 -> 0x7FC00000, done at 2 edges.
  - a=0x00000000, b=0x3F800000 -> 0xBF800000.
  - a=0x7F7FFFFF, b=0xFF7FFFFF -> 0x7F800000.
- Handshake and reset:
  - Hold start high through a 3.0-1.0 run -> exactly one done; a second run starts only after done.
  - Assert reset 2 cycles after accept -> no done, diff=0, busy=0, and the next start completes normally.
- Alignment cap: a=0x4B800000 (2^24), b=0x33800000 (2^-24) -> diff=0x4B800000 via ALIGN_MAX truncation, done at 28 edges.
